// File: rtl/qos_ingress_buffer_pkg.sv
// Shared packet field widths, header layout and node-ID helpers for the QoS ingress buffer.
package qos_ingress_buffer_pkg;

  localparam int TYPE_W  = 2;
  localparam int ID_W    = 6;
  localparam int COORD_W = 3;

  typedef struct packed {
    logic [TYPE_W-1:0] ptype;
    logic              qos;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
  } pkt_hdr_t;

  localparam int HDR_W = $bits(pkt_hdr_t);

  typedef enum logic {
    SEL_FREE   = 1'b0,
    SEL_LOCKED = 1'b1
  } sel_state_t;

  // Node IDs pack mesh coordinates as {y, x}.
  function automatic logic [ID_W-1:0] node_id(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

  function automatic logic is_fault_tgt(input logic            en,
                                        input logic [ID_W-1:0] tgt,
                                        input logic [ID_W-1:0] node);
    return en && (tgt == node);
  endfunction

endpackage

// File: rtl/qos_ingress_buffer_pkt_fifo.sv
// First-word fall-through FIFO with wrap-around pointers and an explicit occupancy count.
module pkt_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // A full queue refuses the push even if it drains the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/qos_ingress_buffer.sv
// Two-class ingress buffer: high/low QoS FIFOs, starvation-bounded arbitration, faulty-node drop.
// state  | meaning
// FREE   | queue selection recomputed every cycle
// LOCKED | presented packet held until the router takes it
module qos_ingress_buffer
  import qos_ingress_buffer_pkg::*;
#(
  parameter int  DEPTH        = 4,
  parameter int  DATA_W       = 8,
  parameter int  STARVE_LIMIT = 8,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_en,
  input  logic [ID_W-1:0]   pg_node,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [TYPE_W-1:0] in_type,
  input  logic              in_qos,
  input  logic [ID_W-1:0]   in_src,
  input  logic [ID_W-1:0]   in_tgt,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [TYPE_W-1:0] out_type,
  output logic              out_qos,
  output logic [ID_W-1:0]   out_src,
  output logic [ID_W-1:0]   out_tgt,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  hi_cnt,
  output logic [CNT_W-1:0]  lo_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int ENT_W = HDR_W + DATA_W;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] hi_ent;
  logic [ENT_W-1:0] lo_ent;
  logic [ENT_W-1:0] sel_ent;
  pkt_hdr_t         sel_hdr;

  logic       hi_full, hi_empty, lo_full, lo_empty;
  logic       drop_pkt, accept, hi_push, lo_push;
  logic       pop, hi_pop, lo_pop;
  logic       sel_lo_free, sel_lo, sel_lo_q;
  sel_state_t state;
  logic [SW-1:0] starve_cnt;

  assign in_ent   = {in_type, in_qos, in_src, in_tgt, in_data};
  assign drop_pkt = is_fault_tgt(pg_en, in_tgt, pg_node);
  assign in_rdy   = drop_pkt ? 1'b1 : (in_qos ? !hi_full : !lo_full);
  assign accept   = in_vld && in_rdy;
  assign hi_push  = accept && !drop_pkt && in_qos;
  assign lo_push  = accept && !drop_pkt && !in_qos;

  assign out_vld     = !hi_empty || !lo_empty;
  assign sel_lo_free = hi_empty || ((starve_cnt == SW'(STARVE_LIMIT)) && !lo_empty);
  assign sel_lo      = (state == SEL_LOCKED) ? sel_lo_q : sel_lo_free;
  assign pop         = out_vld && out_rdy;
  assign hi_pop      = pop && !sel_lo;
  assign lo_pop      = pop && sel_lo;

  // Fields read as zero whenever nothing is presented.
  assign sel_ent  = !out_vld ? '0 : (sel_lo ? lo_ent : hi_ent);
  assign sel_hdr  = pkt_hdr_t'(sel_ent[ENT_W-1 -: HDR_W]);
  assign out_type = sel_hdr.ptype;
  assign out_qos  = sel_hdr.qos;
  assign out_src  = sel_hdr.src;
  assign out_tgt  = sel_hdr.tgt;
  assign out_data = sel_ent[DATA_W-1:0];

  pkt_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_hi_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hi_push),
    .pop   (hi_pop),
    .wdata (in_ent),
    .rdata (hi_ent),
    .full  (hi_full),
    .empty (hi_empty),
    .cnt   (hi_cnt)
  );

  pkt_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_lo_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lo_push),
    .pop   (lo_pop),
    .wdata (in_ent),
    .rdata (lo_ent),
    .full  (lo_full),
    .empty (lo_empty),
    .cnt   (lo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEL_FREE;
      sel_lo_q <= 1'b0;
    end else begin
      case (state)
        SEL_FREE: begin
          if (out_vld && !out_rdy) begin
            state    <= SEL_LOCKED;
            sel_lo_q <= sel_lo_free;
          end
        end
        SEL_LOCKED: begin
          if (out_rdy) state <= SEL_FREE;
        end
      endcase
    end
  end

  // Counts high grants that bypassed a waiting low packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (lo_pop || lo_empty) begin
      starve_cnt <= '0;
    end else if (hi_pop && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (accept && drop_pkt && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_qos_ingress_buffer.sv
// Bench for qos_ingress_buffer: queue-based reference model checked every cycle plus directed scenarios.
module tb_qos_ingress_buffer;
  import qos_ingress_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int CW    = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pg_en;
  logic [5:0] pg_node;
  logic       in_vld, in_rdy, in_qos;
  logic [1:0] in_type;
  logic [5:0] in_src, in_tgt;
  logic [7:0] in_data;
  logic       out_vld, out_rdy, out_qos;
  logic [1:0] out_type;
  logic [5:0] out_src, out_tgt;
  logic [7:0] out_data;
  logic [CW-1:0] hi_cnt, lo_cnt;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  qos_ingress_buffer #(.DEPTH(DEPTH), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .pg_en(pg_en), .pg_node(pg_node),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_type(in_type), .in_qos(in_qos),
    .in_src(in_src), .in_tgt(in_tgt), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_type(out_type), .out_qos(out_qos),
    .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data),
    .hi_cnt(hi_cnt), .lo_cnt(lo_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [1:0] ptype;
    logic       qos;
    logic [5:0] src;
    logic [5:0] tgt;
    logic [7:0] data;
  } mpkt_t;

  mpkt_t hq[$];
  mpkt_t lq[$];
  int    starve;
  bit    held, held_lo;
  int    drops;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_sel_lo();
    if (held) return held_lo;
    if (hq.size() == 0) return 1'b1;
    return (starve == LIMIT) && (lq.size() != 0);
  endfunction

  function automatic bit m_in_rdy();
    if (pg_en && in_tgt == pg_node) return 1'b1;
    return in_qos ? (hq.size() < DEPTH) : (lq.size() < DEPTH);
  endfunction

  // Reference model: whole packets in queues, arbitration by the grant rules.
  always @(posedge clk or negedge rst_n) begin : model
    bit    ov, sl, rdy, drop;
    int    lo_n;
    mpkt_t p;
    if (!rst_n) begin
      hq.delete(); lq.delete();
      starve = 0; held = 0; held_lo = 0; drops = 0;
    end else begin
      ov   = (hq.size() + lq.size()) != 0;
      sl   = m_sel_lo();
      rdy  = m_in_rdy();
      drop = pg_en && (in_tgt == pg_node);
      lo_n = lq.size();
      if (ov && out_rdy) begin
        if (sl) void'(lq.pop_front());
        else    void'(hq.pop_front());
      end
      if (ov && out_rdy && sl)       starve = 0;
      else if (lo_n == 0)            starve = 0;
      else if (ov && out_rdy && !sl) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      held    = ov && !out_rdy;
      held_lo = sl;
      if (in_vld && rdy) begin
        if (drop) begin
          if (drops < 255) drops++;
        end else begin
          p = '{ptype: in_type, qos: in_qos, src: in_src, tgt: in_tgt, data: in_data};
          if (in_qos) hq.push_back(p);
          else        lq.push_back(p);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    mpkt_t e;
    bit    ov;
    if (rst_n) begin
      ov = (hq.size() + lq.size()) != 0;
      e  = '0;
      if (ov) e = m_sel_lo() ? lq[0] : hq[0];
      chk("out_vld", out_vld, ov);
      chk("in_rdy", in_rdy, m_in_rdy());
      chk("hi_cnt", hi_cnt, hq.size());
      chk("lo_cnt", lo_cnt, lq.size());
      chk("drop_cnt", drop_cnt, drops);
      chk("out_pkt", {out_type, out_qos, out_src, out_tgt, out_data}, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit q, input logic [5:0] tgt, input logic [7:0] d);
    in_vld  = v;
    in_qos  = q;
    in_tgt  = tgt;
    in_data = d;
    in_type = 2'd1;
    in_src  = 6'h05;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int         hi_sent;
    int         npops;
    logic [11:0] seq;

    rst_n = 1'b1; pg_en = 1'b0; pg_node = '0; out_rdy = 1'b0;
    drive(0, 0, 6'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_hi_cnt", hi_cnt, 0);
    chk("rst_lo_cnt", lo_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_out_fields", {out_type, out_qos, out_src, out_tgt, out_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single low packet, latency 1, identical fields, then popped.
    drive(1, 0, 6'h12, 8'hA5);
    tick();
    drive(0, 0, 6'h00, 8'h00);
    #1;
    chk("single_vld", out_vld, 1);
    chk("single_fields", {out_type, out_qos, out_src, out_tgt, out_data}, {2'd1, 1'b0, 6'h05, 6'h12, 8'hA5});
    chk("single_lo_cnt", lo_cnt, 1);
    out_rdy = 1'b1;
    tick();
    chk("single_lo_pop", lo_cnt, 0);
    chk("single_empty", out_vld, 0);
    out_rdy = 1'b0;

    // Fill the high queue; only the high side back-pressures.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 6'h20 + 6'(i), 8'h10 + 8'(i));
      tick();
    end
    drive(1, 1, 6'h21, 8'h99);
    #1;
    chk("full_hi_cnt", hi_cnt, 4);
    chk("full_rdy_hi", in_rdy, 0);
    in_qos = 1'b0;
    #1;
    chk("full_rdy_lo", in_rdy, 1);
    in_qos = 1'b1;
    out_rdy = 1'b1;
    tick();
    chk("full_no_push_on_pop", hi_cnt, 3);
    drive(0, 0, 6'h00, 8'h00);
    repeat (4) tick();
    chk("drain1_empty", out_vld, 0);

    // Starvation bound: 4 high + 2 low preloaded, then keep high fed to 10 total.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1, 1, 6'h30, 8'h40 + 8'(i)); tick(); end
    for (int i = 0; i < 2; i++) begin drive(1, 0, 6'h31, 8'h60 + 8'(i)); tick(); end
    hi_sent = 4; npops = 0; seq = '0;
    out_rdy = 1'b1;
    for (int c = 0; c < 60 && npops < 12; c++) begin
      drive(hi_sent < 10, 1, 6'h30, 8'h40 + 8'(hi_sent));
      @(negedge clk);
      if (in_vld && in_rdy) hi_sent++;
      if (out_vld && out_rdy) begin
        seq = {seq[10:0], out_qos};
        npops++;
      end
      tick();
    end
    drive(0, 0, 6'h00, 8'h00);
    chk("starve_pops", npops, 12);
    chk("starve_hi_sent", hi_sent, 10);
    chk("starve_order", seq, 12'b1111_1111_0110);
    tick();
    chk("drain2_empty", out_vld, 0);

    // Low packet presented and held; a high arrival must not preempt it.
    out_rdy = 1'b0;
    drive(1, 0, 6'h0C, 8'h77);
    tick();
    drive(1, 1, 6'h0D, 8'h88);
    tick();
    drive(0, 0, 6'h00, 8'h00);
    repeat (2) tick();
    chk("lock_qos", out_qos, 0);
    chk("lock_data", out_data, 8'h77);
    out_rdy = 1'b1;
    tick();
    chk("lock_next_data", out_data, 8'h88);
    tick();
    chk("drain3_empty", out_vld, 0);

    // Faulty target: accepted even with its queue full, dropped and counted.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1, 1, 6'h22, 8'hB0 + 8'(i)); tick(); end
    pg_en = 1'b1;
    pg_node = node_id(3'd3, 3'd3);
    drive(1, 1, 6'h1B, 8'hD0);
    #1;
    chk("pg_rdy", in_rdy, 1);
    tick();
    chk("pg_drop_cnt", drop_cnt, 1);
    chk("pg_hi_unchanged", hi_cnt, 4);
    drive(1, 0, 6'h1A, 8'hD1);
    tick();
    chk("pg_neighbor_enq", lo_cnt, 1);
    drive(0, 0, 6'h00, 8'h00);
    pg_node = 6'h22;
    out_rdy = 1'b1;
    repeat (7) tick();
    chk("pg_queued_survive", out_vld, 0);
    for (int i = 0; i < 256; i++) begin drive(1, i[0], 6'h22, 8'(i)); tick(); end
    drive(0, 0, 6'h00, 8'h00);
    pg_en = 1'b0;
    chk("drop_saturate", drop_cnt, 255);

    // Reset mid-transfer discards everything.
    out_rdy = 1'b0;
    drive(1, 0, 6'h01, 8'hE0); tick();
    drive(1, 1, 6'h02, 8'hE1); tick();
    drive(1, 0, 6'h03, 8'hE2); tick();
    drive(0, 0, 6'h00, 8'h00);
    out_rdy = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_hi_cnt", hi_cnt, 0);
    chk("midrst_lo_cnt", lo_cnt, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    chk("midrst_fields", {out_type, out_qos, out_src, out_tgt, out_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();
    chk("postrst_out_vld", out_vld, 0);
    chk("postrst_lo_cnt", lo_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qos_ingress_buffer.md
QOS_INGRESS_BUFFER -- requirements
Module: qos_ingress_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per QoS queue (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 8, payload width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, consecutive high-QoS grants allowed while low-QoS waits.
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: pg_en  input  1  fault-node enable.
REQ-007 SHALL have port: pg_node  input  6  faulty node ID {y[2:0],x[2:0]}.
REQ-008 SHALL have ports in_vld input 1, in_rdy output 1, in_type input 2, in_qos input 1, in_src input 6, in_tgt input 6, in_data input DATA_W: upstream (local A port) packet handshake.
REQ-009 SHALL have ports out_vld output 1, out_rdy input 1, out_type output 2, out_qos output 1, out_src output 6, out_tgt output 6, out_data output DATA_W: downstream (router) packet handshake.
REQ-010 SHALL have ports hi_cnt, lo_cnt  output  $clog2(DEPTH)+1  queue occupancies, and drop_cnt  output  8  faulty-target drops.

Function
REQ-011 SHALL transfer on a side when vld && rdy are both high at a rising clk edge.
REQ-012 SHALL route accepted packets to high queue when in_qos=1, low queue when in_qos=0; FIFO order within each queue.
REQ-013 SHALL drive in_rdy = 1 when pg_en && in_tgt==pg_node, else !hi_full when in_qos=1, else !lo_full.
REQ-014 SHALL accept but not enqueue packets with pg_en && in_tgt==pg_node; drop_cnt +1, saturating at 255.
REQ-015 SHALL NOT push into a full queue even when that queue pops the same cycle.
REQ-016 SHALL drive out_vld = !hi_empty || !lo_empty; out_* from head of selected queue (first-word fall-through).
REQ-017 SHALL show a packet pushed into an empty buffer on out_* one cycle after acceptance (latency 1).
REQ-018 SHALL select high queue when non-empty, except low queue when starve_cnt==STARVE_LIMIT and low non-empty; low queue when high empty.
REQ-019 SHALL lock the selection while out_vld && !out_rdy; out_* and selection stay stable until transfer, even if a high packet arrives.
REQ-020 SHALL keep a selection FSM: states FREE (selection recomputed each cycle) and LOCKED (held); FREE->LOCKED on out_vld && !out_rdy; LOCKED->FREE on out_rdy.
REQ-021 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each high pop while low non-empty; clear it on a low pop or when low empty.
REQ-022 SHALL update hi_cnt/lo_cnt by +1 push, -1 pop, unchanged on simultaneous push and pop.
REQ-023 SHALL use wrap-around read/write pointers of $clog2(DEPTH) bits plus occupancy; full = cnt==DEPTH, empty = cnt==0.
REQ-024 SHALL sample pg_en/pg_node combinationally per packet; changing them never alters already-queued packets.

Reset
REQ-025 SHALL on rst_n low immediately clear pointers, counts, starve_cnt, drop_cnt, FSM to FREE; out_vld=0, in_rdy=1, out_* fields 0.
REQ-026 SHALL discard all queued packets when reset asserts mid-operation; no partial transfer after release.

Structure
REQ-027 SHALL import a shared package holding packet field widths (TYPE_W=2, ID_W=6), packet struct typedef, node ID helper.
REQ-028 SHALL instantiate one sub-module, pkt_fifo (parameterised DEPTH/width, push/pop/full/empty/cnt), twice.

Verification
REQ-029 SHALL cover: reset, single qos=0 packet tgt=6'h12 data=8'hA5 -> out_vld next cycle with identical fields, lo_cnt 1->0 on pop.
REQ-030 SHALL cover: out_rdy=0, push 4 qos=1 packets -> hi_cnt=4, in_rdy=0 for qos=1, in_rdy=1 for qos=0.
REQ-031 SHALL cover: 10 high + 2 low queued, out_rdy=1 -> 8 high, then 1 low, then 2 high, then 1 low.
REQ-032 SHALL cover: low packet presented with out_rdy=0, high packet arrives -> out_* holds low packet until out_rdy=1.
REQ-033 SHALL cover: pg_en=1, pg_node=6'h1B, in_tgt=6'h1B -> in_rdy=1, no enqueue, drop_cnt=1; tgt=6'h1A enqueued.
REQ-034 SHALL cover: 3 packets queued, rst_n low mid-transfer -> out_vld=0, counts 0 immediately; no stale packet after release.
